jtcontra_gfx_romarb: RTL and testbench
======================================

JTCONTRA_GFX_ROMARB -- requirements
Module: jtcontra_gfx_romarb

Interface
REQ-001 SHALL have parameter AW, default 18, meaning ROM word-address width.
REQ-002 SHALL have parameter DW, default 16, meaning ROM data width.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have ports tile_cs input 1, tile_addr input AW, tile_ok output 1, tile_data output DW: the tilemap engine's request channel.
REQ-006 SHALL have ports obj_cs input 1, obj_addr input AW, obj_ok output 1, obj_data output DW: the object engine's request channel.
REQ-007 SHALL have ports rom_cs output 1, rom_addr output AW, rom_ok input 1, rom_data input DW: the shared SDRAM graphics slot.
REQ-008 SHALL have port LVBL input 1, vertical blank active-low.
REQ-009 SHALL have port timeout output 1, sticky flag for a stalled SDRAM access.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, HOLD, GAP; all outputs registered.
REQ-011 IDLE: no requester cs -> stay IDLE, rom_cs=0.
REQ-012 IDLE, one cs high -> next cycle: state BUSY, grant to that requester, rom_addr=its addr, rom_cs=1.
REQ-013 IDLE, both cs high, LVBL=1 -> grant tile (active-line priority).
REQ-014 IDLE, both cs high, LVBL=0 -> grant the requester not granted last (round-robin); last_grant resets to obj, so first tie grants tile.
REQ-015 BUSY, rom_ok=1 -> latch rom_data into granted requester's data register, assert its ok, drop rom_cs, go HOLD; all in one edge.
REQ-016 *_ok SHALL rise exactly one cycle after the rom_ok cycle; the non-granted ok stays 0.
REQ-017 HOLD: ok and data held while granted cs=1 and its addr equals latched rom_addr.
REQ-018 HOLD: granted cs=0 or addr change -> clear ok next cycle, go GAP.
REQ-019 GAP: rom_cs=0 for exactly one cycle, then IDLE; a pending request is re-arbitrated from IDLE, so minimum spacing between two rom_cs pulses is 2 cycles.
REQ-020 BUSY, granted cs drops before rom_ok (abort) -> rom_cs=0 next cycle, go GAP, no ok asserted, late rom_ok ignored.
REQ-021 BUSY, granted addr changes with cs held -> rom_cs=0 one cycle (GAP), then re-request with new addr; stale rom_ok in that GAP ignored.
REQ-022 rom_ok outside BUSY SHALL be ignored.
REQ-023 Stall counter, 8 bits, counts BUSY cycles without rom_ok; cleared on entering BUSY.
REQ-024 Stall counter reaches 255 -> timeout=1 (sticky until reset), FSM goes GAP, no ok; counter saturates, no wrap.
REQ-025 *_data registers change only on a rom_ok accepted in BUSY for that requester; otherwise keep last value.
REQ-026 Non-granted requester's cs/addr SHALL have no effect on rom_cs/rom_addr while another requester owns the slot.

Reset
REQ-027 On rst=1 asynchronously: state IDLE, rom_cs=0, rom_addr=0, tile_ok=0, obj_ok=0, tile_data=0, obj_data=0, timeout=0, stall counter=0, last_grant=obj.
REQ-028 Reset mid-BUSY SHALL abandon the access; rom_ok arriving after release, with no request pending, is ignored.
REQ-029 First grant possible on the first rising edge after rst deasserts.

Verification
REQ-030 tile_cs=1, addr=0x12345, rom_ok after 3 cycles with data 0xBEEF -> rom_addr=0x12345, tile_data=0xBEEF, tile_ok=1 the cycle after rom_ok; obj_ok=0.
REQ-031 Both cs=1 at once, LVBL=1 -> tile granted; after tile_cs drops, obj granted 2 cycles later with rom_addr=obj_addr.
REQ-032 Both cs=1 repeatedly, LVBL=0 -> grants alternate tile, obj, tile, obj.
REQ-033 tile_cs drops in BUSY, rom_ok arrives 2 cycles later -> tile_ok stays 0, tile_data unchanged, rom_cs low for 1 cycle.
REQ-034 rom_ok held 0 for 300 cycles in BUSY -> timeout=1 at stall count 255, FSM returns IDLE via GAP, timeout stays 1 until rst.
REQ-035 rst asserted mid-BUSY with obj granted -> all outputs 0 immediately, no clock needed.

Source files
------------

// File: rtl/jtcontra_gfx_romarb_if.sv
// rtl/jtcontra_gfx_romarb_if.sv - request/response bundle for the graphics ROM arbiter
// Purpose : groups the tilemap channel, object channel, shared SDRAM slot,
//           LVBL and the timeout flag into one bundle.
// Ports   : tile_cs/tile_addr -> tile_ok/tile_data   (tilemap engine)
//           obj_cs/obj_addr   -> obj_ok/obj_data     (object engine)
//           rom_cs/rom_addr   <- rom_ok/rom_data     (SDRAM graphics slot)
//           LVBL (vertical blank, active low), timeout (sticky stall flag)
// Modports: slave  - arbiter side
//           master - environment side (engines + SDRAM)
interface jtcontra_gfx_romarb_if #(
   parameter int AW = 18,
   parameter int DW = 16
);
   logic          tile_cs;
   logic [AW-1:0] tile_addr;
   logic          tile_ok;
   logic [DW-1:0] tile_data;
   logic          obj_cs;
   logic [AW-1:0] obj_addr;
   logic          obj_ok;
   logic [DW-1:0] obj_data;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic          rom_ok;
   logic [DW-1:0] rom_data;
   logic          LVBL;
   logic          timeout;

   modport slave (
      input  tile_cs, tile_addr, obj_cs, obj_addr, rom_ok, rom_data, LVBL,
      output tile_ok, tile_data, obj_ok, obj_data, rom_cs, rom_addr, timeout
   );

   modport master (
      output tile_cs, tile_addr, obj_cs, obj_addr, rom_ok, rom_data, LVBL,
      input  tile_ok, tile_data, obj_ok, obj_data, rom_cs, rom_addr, timeout
   );
endinterface

// File: rtl/jtcontra_gfx_romarb.sv
// rtl/jtcontra_gfx_romarb.sv - two-requester arbiter for the shared SDRAM graphics slot
// Purpose : shares one SDRAM slot between the tilemap and object engines.
//           Tile wins ties during the active line; during vblank ties are
//           round-robin. Every access is followed by a one-cycle GAP.
// Ports   : clk, rst (async, active high)
//           bus (slave modport) - tile/obj request channels, rom slot,
//           LVBL and the sticky timeout flag.
module jtcontra_gfx_romarb #(
   parameter int AW = 18,
   parameter int DW = 16
) (
   input  logic                    rst,
   input  logic                    clk,
   jtcontra_gfx_romarb_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD, GAP} state_t;

   localparam logic GNT_TILE = 1'b0;
   localparam logic GNT_OBJ  = 1'b1;

   state_t        state;
   logic          grant;
   logic          last_grant;
   logic [7:0]    stall;
   logic          req_cs;
   logic [AW-1:0] req_addr;
   logic          pick;
   logic [DW-1:0] rd;

   assign rd = bus.rom_data;

   always_comb begin
      // Requester currently owning the slot; the other one is invisible here.
      req_cs   = (grant == GNT_OBJ) ? bus.obj_cs   : bus.tile_cs;
      req_addr = (grant == GNT_OBJ) ? bus.obj_addr : bus.tile_addr;
      if (bus.tile_cs && bus.obj_cs)
         pick = bus.LVBL ? GNT_TILE : ~last_grant;
      else
         pick = bus.tile_cs ? GNT_TILE : GNT_OBJ;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= GNT_TILE;
         last_grant    <= GNT_OBJ;
         stall         <= 8'd0;
         bus.rom_cs    <= 1'b0;
         bus.rom_addr  <= '0;
         bus.tile_ok   <= 1'b0;
         bus.obj_ok    <= 1'b0;
         bus.tile_data <= '0;
         bus.obj_data  <= '0;
         bus.timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.tile_cs || bus.obj_cs) begin
                  state        <= BUSY;
                  grant        <= pick;
                  last_grant   <= pick;
                  stall        <= 8'd0;
                  bus.rom_cs   <= 1'b1;
                  bus.rom_addr <= (pick == GNT_OBJ) ? bus.obj_addr : bus.tile_addr;
               end
            end
            BUSY: begin
               // A withdrawn or moved request takes precedence over rom_ok so
               // that data for a stale address never reaches the requester.
               if (!req_cs || req_addr != bus.rom_addr) begin
                  bus.rom_cs <= 1'b0;
                  state      <= GAP;
               end else if (bus.rom_ok) begin
                  bus.rom_cs <= 1'b0;
                  state      <= HOLD;
                  if (grant == GNT_OBJ) begin
                     bus.obj_ok   <= 1'b1;
                     bus.obj_data <= rd;
                  end else begin
                     bus.tile_ok   <= 1'b1;
                     bus.tile_data <= rd;
                  end
               end else if (stall == 8'd254) begin
                  // This cycle is the 255th without rom_ok: give up the slot.
                  stall       <= 8'd255;
                  bus.timeout <= 1'b1;
                  bus.rom_cs  <= 1'b0;
                  state       <= GAP;
               end else begin
                  stall <= stall + 8'd1;
               end
            end
            HOLD: begin
               if (!req_cs || req_addr != bus.rom_addr) begin
                  bus.tile_ok <= 1'b0;
                  bus.obj_ok  <= 1'b0;
                  state       <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// tb/tb_jtcontra_gfx_romarb.sv - self-checking bench for jtcontra_gfx_romarb
module tb_jtcontra_gfx_romarb;
   localparam int AW = 18;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtcontra_gfx_romarb_if #(.AW(AW), .DW(DW)) bus();

   jtcontra_gfx_romarb #(.AW(AW), .DW(DW)) dut (
      .rst (rst),
      .clk (clk),
      .bus (bus)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model: who was granted last, last data delivered per requester,
   // and the sticky timeout flag.
   logic          last_obj;
   logic [DW-1:0] m_tile_d;
   logic [DW-1:0] m_obj_d;
   logic          m_timeout;

   function automatic logic exp_grant(input logic t, input logic o, input logic lv);
      if (t && o) return lv ? 1'b0 : ~last_obj;
      return o;
   endfunction

   task automatic clear_inputs();
      bus.tile_cs   = 1'b0;
      bus.tile_addr = '0;
      bus.obj_cs    = 1'b0;
      bus.obj_addr  = '0;
      bus.rom_ok    = 1'b0;
      bus.rom_data  = '0;
      bus.LVBL      = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst       = 1'b0;
      last_obj  = 1'b1;
      m_tile_d  = '0;
      m_obj_d   = '0;
      m_timeout = 1'b0;
   endtask

   // Waits (bounded) for rom_cs; returns 0 if it never rose.
   task automatic wait_rom_cs(output bit seen);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rom_cs && n < 8);
      seen = bus.rom_cs;
      nvec++;
      if (!seen) begin
         nerr++;
         $display("FAIL grant_wait: rom_cs=%0b after %0d cycles, want 1", bus.rom_cs, n);
      end
   endtask

   // One complete access with random disturbance on the non-granted channel.
   task automatic run_txn(input logic t_req, input logic o_req,
                          input logic [AW-1:0] ta, input logic [AW-1:0] oa,
                          input logic [DW-1:0] d, input int lat, input int hold,
                          input logic lv);
      logic g;
      logic [AW-1:0] ea;
      bit seen;
      g  = exp_grant(t_req, o_req, lv);
      ea = g ? oa : ta;
      bus.tile_cs = t_req; bus.tile_addr = ta;
      bus.obj_cs  = o_req; bus.obj_addr  = oa;
      bus.LVBL    = lv;
      wait_rom_cs(seen);
      if (!seen) begin clear_inputs(); return; end
      last_obj = g;
      nvec++;
      if (bus.rom_addr !== ea) begin
         nerr++;
         $display("FAIL txn_addr: rom_addr=%h want %h", bus.rom_addr, ea);
      end
      for (int i = 0; i < lat; i++) begin
         if (g) begin
            if (!t_req) bus.tile_cs = 1'($urandom);
            bus.tile_addr = AW'($urandom);
         end else begin
            if (!o_req) bus.obj_cs = 1'($urandom);
            bus.obj_addr = AW'($urandom);
         end
         bus.LVBL = 1'($urandom);
         @(negedge clk);
         nvec++;
         if (bus.rom_cs !== 1'b1 || bus.rom_addr !== ea) begin
            nerr++;
            $display("FAIL txn_busy: rom_cs=%0b rom_addr=%h want 1 %h", bus.rom_cs, bus.rom_addr, ea);
         end
      end
      bus.rom_ok = 1'b1; bus.rom_data = d;
      @(negedge clk);
      bus.rom_ok = 1'b0; bus.rom_data = DW'($urandom);
      if (g) m_obj_d = d; else m_tile_d = d;
      for (int h = 0; h <= hold; h++) begin
         nvec++;
         if (bus.tile_ok !== !g || bus.obj_ok !== g || bus.rom_cs !== 1'b0 ||
             bus.tile_data !== m_tile_d || bus.obj_data !== m_obj_d || bus.timeout !== m_timeout) begin
            nerr++;
            $display("FAIL txn_ok: ok t/o=%0b/%0b cs=%0b data t/o=%h/%h to=%0b want %0b/%0b 0 %h/%h %0b",
                     bus.tile_ok, bus.obj_ok, bus.rom_cs, bus.tile_data, bus.obj_data, bus.timeout,
                     !g, g, m_tile_d, m_obj_d, m_timeout);
         end
         if (h < hold) @(negedge clk);
      end
      bus.tile_cs = 1'b0; bus.obj_cs = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.tile_ok !== 1'b0 || bus.obj_ok !== 1'b0 || bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL txn_release: ok t/o=%0b/%0b rom_cs=%0b want 0/0 0", bus.tile_ok, bus.obj_ok, bus.rom_cs);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b0 || bus.rom_addr !== '0 || bus.tile_ok !== 1'b0 || bus.obj_ok !== 1'b0 ||
          bus.tile_data !== '0 || bus.obj_data !== '0 || bus.timeout !== 1'b0) begin
         nerr++;
         $display("FAIL reset_state: cs=%0b addr=%h ok=%0b/%0b data=%h/%h to=%0b want all 0",
                  bus.rom_cs, bus.rom_addr, bus.tile_ok, bus.obj_ok, bus.tile_data, bus.obj_data, bus.timeout);
      end
      rst = 1'b0;
      last_obj = 1'b1; m_tile_d = '0; m_obj_d = '0; m_timeout = 1'b0;
      bus.tile_cs = 1'b1; bus.tile_addr = 18'h0aaaa;
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'h0aaaa) begin
         nerr++;
         $display("FAIL first_grant: rom_cs=%0b rom_addr=%h want 1 0aaaa", bus.rom_cs, bus.rom_addr);
      end
      last_obj = 1'b0;
      bus.tile_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      run_txn(1'b1, 1'b0, 18'h12345, 18'h00000, 16'hbeef, 3, 0, 1'b1);
      run_txn(1'b0, 1'b1, 18'h00000, 18'h3abcd, 16'h1234, 0, 2, 1'b1);
   endtask

   task automatic test_priority();
      bit seen;
      do_reset();
      bus.LVBL = 1'b1;
      bus.tile_cs = 1'b1; bus.tile_addr = 18'h01111;
      bus.obj_cs  = 1'b1; bus.obj_addr  = 18'h02222;
      wait_rom_cs(seen);
      nvec++;
      if (bus.rom_addr !== 18'h01111) begin
         nerr++;
         $display("FAIL prio_tile: rom_addr=%h want 01111", bus.rom_addr);
      end
      bus.rom_ok = 1'b1; bus.rom_data = 16'h00a5;
      @(negedge clk);
      bus.rom_ok = 1'b0;
      bus.tile_cs = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.tile_ok !== 1'b0 || bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL prio_clear: tile_ok=%0b rom_cs=%0b want 0 0", bus.tile_ok, bus.rom_cs);
      end
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL prio_spacing: rom_cs=%0b want 0", bus.rom_cs);
      end
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'h02222) begin
         nerr++;
         $display("FAIL prio_obj: rom_cs=%0b rom_addr=%h want 1 02222", bus.rom_cs, bus.rom_addr);
      end
      last_obj = 1'b1;
      bus.obj_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit seen;
      logic g;
      logic [AW-1:0] ea;
      do_reset();
      bus.LVBL = 1'b0;
      bus.tile_cs = 1'b1; bus.tile_addr = 18'h00100;
      bus.obj_cs  = 1'b1; bus.obj_addr  = 18'h20100;
      for (int k = 0; k < 4; k++) begin
         g  = exp_grant(1'b1, 1'b1, 1'b0);
         ea = g ? bus.obj_addr : bus.tile_addr;
         nvec++;
         if (g !== 1'(k)) begin
            nerr++;
            $display("FAIL rr_model: grant %0d model=%0b want %0b", k, g, 1'(k));
         end
         wait_rom_cs(seen);
         last_obj = g;
         nvec++;
         if (bus.rom_addr !== ea) begin
            nerr++;
            $display("FAIL rr_grant: round %0d rom_addr=%h want %h", k, bus.rom_addr, ea);
         end
         bus.rom_ok = 1'b1; bus.rom_data = 16'h5000 + 16'(k);
         @(negedge clk);
         bus.rom_ok = 1'b0;
         nvec++;
         if (bus.tile_ok !== !g || bus.obj_ok !== g) begin
            nerr++;
            $display("FAIL rr_ok: round %0d ok t/o=%0b/%0b want %0b/%0b", k, bus.tile_ok, bus.obj_ok, !g, g);
         end
         // Moving the owner's address releases the slot while both stay pending.
         if (g) bus.obj_addr = bus.obj_addr + 18'd1;
         else   bus.tile_addr = bus.tile_addr + 18'd1;
      end
      clear_inputs();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_abort();
      bit seen;
      do_reset();
      run_txn(1'b1, 1'b0, 18'h00321, 18'h0, 16'hc0de, 1, 0, 1'b1);
      bus.tile_cs = 1'b1; bus.tile_addr = 18'h00777;
      wait_rom_cs(seen);
      last_obj = 1'b0;
      bus.tile_cs = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL abort_cs: rom_cs=%0b want 0", bus.rom_cs);
      end
      @(negedge clk);
      bus.rom_ok = 1'b1; bus.rom_data = 16'h5555;
      @(negedge clk);
      bus.rom_ok = 1'b0;
      nvec++;
      if (bus.tile_ok !== 1'b0 || bus.tile_data !== m_tile_d || bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL abort_late_ok: tile_ok=%0b tile_data=%h rom_cs=%0b want 0 %h 0",
                  bus.tile_ok, bus.tile_data, bus.rom_cs, m_tile_d);
      end
      // Address change with cs held: one GAP, stale rom_ok ignored, re-request.
      bus.obj_cs = 1'b1; bus.obj_addr = 18'h01000;
      wait_rom_cs(seen);
      last_obj = 1'b1;
      bus.obj_addr = 18'h01001;
      @(negedge clk);
      bus.rom_ok = 1'b1; bus.rom_data = 16'h6666;
      nvec++;
      if (bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL move_gap: rom_cs=%0b want 0", bus.rom_cs);
      end
      @(negedge clk);
      bus.rom_ok = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'h01001 || bus.obj_ok !== 1'b0 || bus.obj_data !== m_obj_d) begin
         nerr++;
         $display("FAIL move_rerequest: cs=%0b addr=%h obj_ok=%0b obj_data=%h want 1 01001 0 %h",
                  bus.rom_cs, bus.rom_addr, bus.obj_ok, bus.obj_data, m_obj_d);
      end
      bus.obj_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic t, o;
      int sel;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 2));
         t = (sel != 1);
         o = (sel != 0);
         run_txn(t, o, AW'($urandom), AW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'($urandom));
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int cnt;
      bus.tile_cs = 1'b1; bus.tile_addr = 18'h0dead;
      wait_rom_cs(seen);
      last_obj = 1'b0;
      cnt = 0;
      while (bus.rom_cs && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      bus.tile_cs = 1'b0;
      m_timeout = 1'b1;
      nvec++;
      if (cnt !== 255 || bus.timeout !== 1'b1 || bus.tile_ok !== 1'b0) begin
         nerr++;
         $display("FAIL timeout_fire: busy=%0d timeout=%0b tile_ok=%0b want 255 1 0", cnt, bus.timeout, bus.tile_ok);
      end
      repeat (20) @(negedge clk);
      nvec++;
      if (bus.timeout !== 1'b1 || bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL timeout_sticky: timeout=%0b rom_cs=%0b want 1 0", bus.timeout, bus.rom_cs);
      end
      run_txn(1'b0, 1'b1, 18'h0, 18'h0beef, 16'h7777, 2, 0, 1'b1);
   endtask

   task automatic test_reset_midbusy();
      bit seen;
      bus.obj_cs = 1'b1; bus.obj_addr = 18'h3ffff;
      wait_rom_cs(seen);
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (bus.rom_cs !== 1'b0 || bus.rom_addr !== '0 || bus.tile_ok !== 1'b0 || bus.obj_ok !== 1'b0 ||
          bus.tile_data !== '0 || bus.obj_data !== '0 || bus.timeout !== 1'b0) begin
         nerr++;
         $display("FAIL reset_async: cs=%0b addr=%h ok=%0b/%0b data=%h/%h to=%0b want all 0",
                  bus.rom_cs, bus.rom_addr, bus.tile_ok, bus.obj_ok, bus.tile_data, bus.obj_data, bus.timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.obj_cs = 1'b0;
      bus.rom_ok = 1'b1; bus.rom_data = 16'h9999;
      @(negedge clk);
      bus.rom_ok = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.obj_ok !== 1'b0 || bus.obj_data !== '0 || bus.rom_cs !== 1'b0) begin
         nerr++;
         $display("FAIL reset_late_ok: obj_ok=%0b obj_data=%h rom_cs=%0b want 0 0 0", bus.obj_ok, bus.obj_data, bus.rom_cs);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_round_robin();
      test_abort();
      test_random();
      test_timeout();
      test_reset_midbusy();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
